// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the round-robin arbiter and its picker.
// The arbiter's grant bus feeds the 8-to-3 encoder, hence ARB_N.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N = 8;

  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ARB_PTR_W = ptr_w(ARB_N);

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set bit of vec_i at or above
// ptr_i, wrapping N-1 -> 0. Returns the one-hot choice, its index and a hit flag.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = ARB_N
) (
  input  logic [N-1:0]        vec_i,
  input  logic [ptr_w(N)-1:0] ptr_i,
  output logic [N-1:0]        onehot_o,
  output logic [ptr_w(N)-1:0] idx_o,
  output logic                any_o
);

  localparam int PW = ptr_w(N);

  logic          found;
  logic [PW-1:0] pos;

  // N is a power of two, so the PW-bit sum wraps the search naturally.
  always_comb begin
    found    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    pos      = '0;
    for (int k = 0; k < N; k++) begin
      pos = ptr_i + PW'(k);
      if (!found && vec_i[pos]) begin
        found = 1'b1;
        idx_o = pos;
      end
    end
    if (found) onehot_o[idx_o] = 1'b1;
    any_o = found;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with bounded hold under contention.
// Grant is one-hot or zero and drives the downstream 8-to-3 encoder directly.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_valid
);

  localparam int PW = ptr_w(N);
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit PREEMPT_EN = (MAX_HOLD != 0);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          gnt_valid_q;
  logic [PW-1:0] gidx_q, gidx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [N-1:0]  full_oh, excl_oh;
  logic [PW-1:0] full_idx, excl_idx;
  logic          full_any, excl_any;
  logic [N-1:0]  req_excl;

  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] h);
    return (h == HOLD_LAST) ? h : h + HW'(1);
  endfunction

  assign req_excl = req & ~gnt_q;

  rr_pick #(.N(N)) u_pick_full (
    .vec_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (full_oh),
    .idx_o    (full_idx),
    .any_o    (full_any)
  );

  rr_pick #(.N(N)) u_pick_excl (
    .vec_i    (req_excl),
    .ptr_i    (ptr_q),
    .onehot_o (excl_oh),
    .idx_o    (excl_idx),
    .any_o    (excl_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (full_any) begin
          gnt_d   = full_oh;
          gidx_d  = full_idx;
          ptr_d   = full_idx + PW'(1);
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Handover, whether on release or on timeout, lands on one edge.
        if (!req[gidx_q]) begin
          if (excl_any) begin
            gnt_d  = excl_oh;
            gidx_d = excl_idx;
            ptr_d  = excl_idx + PW'(1);
            hold_d = '0;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (excl_any && PREEMPT_EN && (hold_q == HOLD_LAST)) begin
          gnt_d  = excl_oh;
          gidx_d = excl_idx;
          ptr_d  = excl_idx + PW'(1);
          hold_d = '0;
        end else begin
          hold_d = sat_inc(hold_q);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (N=8, MAX_HOLD=4): directed scenarios plus random
// request traffic, all checked against a behavioural round-robin model.
module tb_rr_arbiter;

  localparam int N  = 8;
  localparam int MH = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: current owner (-1 = none), priority pointer, cycles owned so far.
  int m_owner;
  int m_ptr;
  int m_held;

  rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
  endtask

  function automatic int m_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic int enc_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic m_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
  endtask

  task automatic m_grant(input int p);
    m_owner = p;
    m_ptr   = (p + 1) % N;
    m_held  = 1;
  endtask

  task automatic m_step(input logic [N-1:0] r);
    logic [N-1:0] others;
    if (m_owner < 0) begin
      if (r != 0) m_grant(m_pick(r, m_ptr));
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        if (others != 0) m_grant(m_pick(others, m_ptr));
        else m_owner = -1;
      end else if (others != 0 && m_held >= MH) begin
        m_grant(m_pick(others, m_ptr));
      end else begin
        m_held++;
      end
    end
  endtask

  // Apply r for one rising edge, advance the model, compare just after the edge.
  task automatic cycle(input logic [N-1:0] r, input string tag);
    req = r;
    @(posedge clk);
    m_step(r);
    #1;
    check_eq({tag, ".gnt"}, gnt, m_gnt());
    check_eq({tag, ".vld"}, 8'(gnt_valid), 8'(m_owner >= 0));
  endtask

  initial begin
    bit seen;
    logic [N-1:0] r;

    m_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("rst.gnt", gnt, 8'h00);
      check_eq("rst.vld", 8'(gnt_valid), 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(8'h00, "idle");

    cycle(8'h10, "single");
    check_eq("single.enc", 8'(enc_idx(gnt)), 8'd4);
    cycle(8'h00, "single_rel");

    repeat (40) cycle(8'hFF, "full");

    cycle(8'h00, "pre_rel");
    rst_n = 1'b0;
    m_reset();
    #1;
    rst_n = 1'b1;
    repeat (5) cycle(8'h45, "rel_setup");
    check_eq("rel.setup", gnt, 8'h04);
    cycle(8'h41, "rel");
    check_eq("rel.handover", gnt, 8'h40);

    cycle(8'h00, "sole_idle");
    repeat (12) begin
      cycle(8'h08, "sole");
      check_eq("sole.keep", gnt, 8'h08);
    end
    seen = 1'b0;
    for (int i = 0; i < MH; i++) begin
      cycle(8'h0A, "sole_pre");
      if (gnt == 8'h02) seen = 1'b1;
    end
    check_eq("sole.preempted", 8'(seen), 8'h01);

    cycle(8'h00, "ar_idle");
    cycle(8'h20, "ar_grant");
    check_eq("ar.pre", gnt, 8'h20);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_eq("ar.gnt_async", gnt, 8'h00);
    check_eq("ar.vld_async", 8'(gnt_valid), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'hFF, "ar_after");
    check_eq("ar.first", gnt, 8'h01);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom);
        1: r = 8'($urandom) & 8'($urandom);
        2: r = (i % 50 < 25) ? 8'hFF : 8'($urandom);
        default: r = req ^ (8'h01 << $urandom_range(0, N - 1));
      endcase
      cycle(r, "rand");
      check_eq("rand.onehot", 8'($onehot0(gnt)), 8'h01);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
